// File: rtl/msrv32_pkg.sv
// Shared constants and types for the multi-port RV32 register file.
package msrv32_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int AW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);

  // Architectural zero register; never written, always reads 0.
  localparam int REG_ZERO = 0;

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/msrv32_mp_reg_file_if.sv
// Bus bundle between the issue/writeback logic (master) and the register file (slave).
interface msrv32_mp_reg_file_if
  import msrv32_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]   rd_addr_in;
  logic [NUM_RD*XLEN-1:0] rd_data_out;
  logic [NUM_RD-1:0]      rd_busy_out;
  logic [NUM_WR-1:0]      wr_en_in;
  logic [NUM_WR*AW-1:0]   wr_addr_in;
  logic [NUM_WR*XLEN-1:0] wr_data_in;
  logic [NUM_WR-1:0]      wr_clr_busy_in;
  logic                   sb_set_en_in;
  logic [AW-1:0]          sb_set_addr_in;
  logic [NUM_REGS-1:0]    busy_vec_out;

  modport master (
    output rd_addr_in, wr_en_in, wr_addr_in, wr_data_in, wr_clr_busy_in,
           sb_set_en_in, sb_set_addr_in,
    input  rd_data_out, rd_busy_out, busy_vec_out
  );

  modport slave (
    input  rd_addr_in, wr_en_in, wr_addr_in, wr_data_in, wr_clr_busy_in,
           sb_set_en_in, sb_set_addr_in,
    output rd_data_out, rd_busy_out, busy_vec_out
  );

endinterface

// File: rtl/msrv32_rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, set wins
// over clear on the same register. Bit 0 (x0) is never busy.
module msrv32_rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR-1:0]    wr_clr_busy,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Decode set/clear hits per register and resolve with set priority.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    busy_d  = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      set_vec[r] = set_en && (set_addr == AW'(r));
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_clr_busy[j] && (wr_addr[j*AW +: AW] == AW'(r)))
          clr_vec[r] = 1'b1;
      end
      if (set_vec[r])
        busy_d[r] = 1'b1;
      else if (clr_vec[r])
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // Busy lookup for each read port; intentionally not bypassed.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++)
      rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/msrv32_mp_reg_file.sv
// Multi-port RV32 integer register file with busy scoreboard.
// Optional feature: define MSRV32_RF_BYPASS_EN for same-cycle write-to-read
// forwarding (highest-index matching write port wins).
module msrv32_mp_reg_file
  import msrv32_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_n_in,
  msrv32_mp_reg_file_if.slave   bus
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [AW-1:0]   rd_addr_k [NUM_RD];
  logic [XLEN-1:0] rd_val_k  [NUM_RD];

  // Apply writes in ascending port order so the higher-index port wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en_in[j] && (bus.wr_addr_in[j*AW +: AW] != ZERO_ADDR))
        regs_d[bus.wr_addr_in[j*AW +: AW]] = bus.wr_data_in[j*XLEN +: XLEN];
    end
    regs_d[REG_ZERO] = '0;
  end

  // Register array storage.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in)
      regs_q <= '{default: '0};
    else
      regs_q <= regs_d;
  end

  // Combinational read ports, with optional forwarding from the write ports.
  always_comb begin
    bus.rd_data_out = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr_k[k] = bus.rd_addr_in[k*AW +: AW];
      rd_val_k[k]  = regs_q[rd_addr_k[k]];
`ifdef MSRV32_RF_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en_in[j] && (bus.wr_addr_in[j*AW +: AW] != ZERO_ADDR) &&
            (bus.wr_addr_in[j*AW +: AW] == rd_addr_k[k]))
          rd_val_k[k] = bus.wr_data_in[j*XLEN +: XLEN];
      end
`endif
      if (rd_addr_k[k] == ZERO_ADDR)
        rd_val_k[k] = '0;
      bus.rd_data_out[k*XLEN +: XLEN] = rd_val_k[k];
    end
  end

  msrv32_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (ms_riscv32_mp_clk_in),
    .rst_n       (ms_riscv32_mp_rst_n_in),
    .set_en      (bus.sb_set_en_in),
    .set_addr    (bus.sb_set_addr_in),
    .wr_en       (bus.wr_en_in),
    .wr_addr     (bus.wr_addr_in),
    .wr_clr_busy (bus.wr_clr_busy_in),
    .rd_addr     (bus.rd_addr_in),
    .rd_busy     (bus.rd_busy_out),
    .busy_vec    (bus.busy_vec_out)
  );

endmodule

// File: tb/tb_msrv32_mp_reg_file.sv
// Directed self-checking bench for msrv32_mp_reg_file (2 read, 2 write ports).
module tb_msrv32_mp_reg_file;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  msrv32_mp_reg_file_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  msrv32_mp_reg_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .bus                    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en_in       = '0;
    bus.wr_addr_in     = '0;
    bus.wr_data_in     = '0;
    bus.wr_clr_busy_in = '0;
    bus.sb_set_en_in   = 1'b0;
    bus.sb_set_addr_in = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr_in = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rd_addr_in = '0;
    idle_inputs();
    tick();
    tick();
    for (int a = 0; a < NUM_REGS; a++) begin
      set_rd(5'(a), 5'(NUM_REGS - 1 - a));
      vectors++;
      if (bus.rd_data_out[31:0] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rd0 addr=%0d got=%h want=0", a, bus.rd_data_out[31:0]);
      end
      vectors++;
      if (bus.rd_data_out[63:32] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rd1 addr=%0d got=%h want=0", NUM_REGS - 1 - a, bus.rd_data_out[63:32]);
      end
    end
    vectors++;
    if (bus.busy_vec_out !== 32'h0 || bus.rd_busy_out !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_busy got vec=%h rd=%b want 0", bus.busy_vec_out, bus.rd_busy_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    bus.wr_en_in = 2'b01; bus.wr_addr_in = {5'd0, 5'd5}; bus.wr_data_in = {32'h0, 32'hDEADBEEF};
    tick();
    idle_inputs();
    set_rd(5'd5, 5'd5);
    vectors++;
    if (bus.rd_data_out !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL write_addr5 got=%h want=deadbeefdeadbeef", bus.rd_data_out);
    end
    bus.wr_en_in = 2'b01; bus.wr_addr_in = {5'd0, 5'd0}; bus.wr_data_in = {32'h0, 32'h12345678};
    set_rd(5'd0, 5'd0);
    vectors++;
    if (bus.rd_data_out !== 64'h0) begin
      miscompares++;
      $display("FAIL x0_same_cycle got=%h want=0", bus.rd_data_out);
    end
    tick();
    idle_inputs();
    set_rd(5'd0, 5'd5);
    vectors++;
    if (bus.rd_data_out !== {32'hDEADBEEF, 32'h0}) begin
      miscompares++;
      $display("FAIL x0_after_write got=%h want=deadbeef00000000", bus.rd_data_out);
    end
  endtask

  task automatic test_dual_write();
    bus.wr_en_in = 2'b11; bus.wr_addr_in = {5'd7, 5'd7}; bus.wr_data_in = {32'h2222, 32'h1111};
    tick();
    idle_inputs();
    set_rd(5'd7, 5'd7);
    vectors++;
    if (bus.rd_data_out !== {32'h2222, 32'h2222}) begin
      miscompares++;
      $display("FAIL dual_write_prio got=%h want=0000222200002222", bus.rd_data_out);
    end
    // Only port 0 enabled: it must write even though port 1 is higher priority.
    bus.wr_en_in = 2'b01; bus.wr_addr_in = {5'd7, 5'd7}; bus.wr_data_in = {32'h3333, 32'h4444};
    tick();
    idle_inputs();
    set_rd(5'd7, 5'd0);
    vectors++;
    if (bus.rd_data_out[31:0] !== 32'h4444) begin
      miscompares++;
      $display("FAIL port0_only got=%h want=00004444", bus.rd_data_out[31:0]);
    end
  endtask

  task automatic test_bypass();
    set_rd(5'd9, 5'd5);
    bus.wr_en_in = 2'b01; bus.wr_addr_in = {5'd0, 5'd9}; bus.wr_data_in = {32'h0, 32'hA5A5A5A5};
    #1;
    vectors++;
`ifdef MSRV32_RF_BYPASS_EN
    if (bus.rd_data_out[31:0] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_same_cycle got=%h want=a5a5a5a5", bus.rd_data_out[31:0]);
    end
`else
    if (bus.rd_data_out[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL no_bypass_same_cycle got=%h want=00000000", bus.rd_data_out[31:0]);
    end
`endif
    vectors++;
    if (bus.rd_data_out[63:32] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_other_port got=%h want=deadbeef", bus.rd_data_out[63:32]);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rd_data_out[31:0] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL write9_next_cycle got=%h want=a5a5a5a5", bus.rd_data_out[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    bus.sb_set_en_in = 1'b1; bus.sb_set_addr_in = 5'd3;
    set_rd(5'd3, 5'd4);
    vectors++;
    if (bus.rd_busy_out !== 2'b00) begin
      miscompares++;
      $display("FAIL busy_before_edge got=%b want=00", bus.rd_busy_out);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rd_busy_out !== 2'b01 || bus.busy_vec_out !== 32'h8) begin
      miscompares++;
      $display("FAIL busy_set3 got rd=%b vec=%h want rd=01 vec=00000008", bus.rd_busy_out, bus.busy_vec_out);
    end
    // clr_busy without wr_en must not clear.
    bus.wr_clr_busy_in = 2'b11; bus.wr_addr_in = {5'd3, 5'd3};
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.busy_vec_out !== 32'h8) begin
      miscompares++;
      $display("FAIL clr_without_en got=%h want=00000008", bus.busy_vec_out);
    end
    // Writeback with clear on port 1: busy stays high this cycle, drops next.
    bus.wr_en_in = 2'b10; bus.wr_clr_busy_in = 2'b10; bus.wr_addr_in = {5'd3, 5'd0};
    bus.wr_data_in = {32'hCAFEF00D, 32'h0};
    #1;
    vectors++;
    if (bus.rd_busy_out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_not_bypassed got=%b want=1", bus.rd_busy_out[0]);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rd_busy_out[0] !== 1'b0 || bus.busy_vec_out !== 32'h0 || bus.rd_data_out[31:0] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL busy_cleared got rd=%b vec=%h data=%h want 0/0/cafef00d",
               bus.rd_busy_out[0], bus.busy_vec_out, bus.rd_data_out[31:0]);
    end
    // Set 3 and 4 on consecutive cycles, then set+clear 3 in one cycle.
    bus.sb_set_en_in = 1'b1; bus.sb_set_addr_in = 5'd3;
    tick();
    bus.sb_set_addr_in = 5'd4;
    tick();
    bus.sb_set_addr_in = 5'd3;
    bus.wr_en_in = 2'b11; bus.wr_clr_busy_in = 2'b01; bus.wr_addr_in = {5'd9, 5'd3};
    bus.wr_data_in = {32'h99, 32'h33};
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rd_busy_out !== 2'b11 || bus.busy_vec_out !== 32'h18) begin
      miscompares++;
      $display("FAIL set_beats_clr got rd=%b vec=%h want rd=11 vec=00000018", bus.rd_busy_out, bus.busy_vec_out);
    end
    // Clearing a non-busy register is a no-op; x0 can never become busy.
    bus.sb_set_en_in = 1'b1; bus.sb_set_addr_in = 5'd0;
    bus.wr_en_in = 2'b01; bus.wr_clr_busy_in = 2'b01; bus.wr_addr_in = {5'd0, 5'd9};
    bus.wr_data_in = {32'h0, 32'h9A};
    tick();
    idle_inputs();
    set_rd(5'd0, 5'd9);
    vectors++;
    if (bus.busy_vec_out !== 32'h18 || bus.rd_busy_out !== 2'b00) begin
      miscompares++;
      $display("FAIL set_x0 got vec=%h rd=%b want vec=00000018 rd=00", bus.busy_vec_out, bus.rd_busy_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en_in   = 2'b11;
      bus.wr_addr_in = {5'(20 + i), 5'(10 + i)};
      bus.wr_data_in = {32'(32'hB000 + i), 32'(32'hA000 + i)};
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      set_rd(5'(10 + i), 5'(20 + i));
      vectors++;
      if (bus.rd_data_out !== {32'(32'hB000 + i), 32'(32'hA000 + i)}) begin
        miscompares++;
        $display("FAIL b2b idx=%0d got=%h want=%h", i, bus.rd_data_out,
                 {32'(32'hB000 + i), 32'(32'hA000 + i)});
      end
    end
  endtask

  task automatic test_reset_midstream();
    set_rd(5'd5, 5'd3);
    bus.sb_set_en_in = 1'b1; bus.sb_set_addr_in = 5'd5;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rd_busy_out !== 2'b11 || bus.rd_data_out[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL pre_reset got rd=%b data=%h want rd=11 data=deadbeef", bus.rd_busy_out, bus.rd_data_out[31:0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.rd_data_out !== 64'h0 || bus.rd_busy_out !== 2'b00 || bus.busy_vec_out !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset got data=%h rd=%b vec=%h want all 0",
               bus.rd_data_out, bus.rd_busy_out, bus.busy_vec_out);
    end
    #1;
    rst_n = 1'b1;
    bus.wr_en_in = 2'b01; bus.wr_addr_in = {5'd0, 5'd4}; bus.wr_data_in = {32'h0, 32'h55};
    set_rd(5'd4, 5'd3);
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rd_data_out !== {32'h0, 32'h55}) begin
      miscompares++;
      $display("FAIL write_after_release got=%h want=0000000000000055", bus.rd_data_out);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
